// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded instruction and forwards EX/MEM results into its operands.
// Latency: 1 cycle from capture to out_valid. Throughput: 1 instruction per cycle. Operands are combinational from the held entry.
// Backpressure: in_ready = !out_valid || out_ready. A stalled entry keeps absorbing forwarded values. flush drops both the held and the incoming instruction.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 branch redirect; kills the held and the incoming instruction
//   in_valid/in_ready     decode handshake
//   in_*                  decoded instruction fields (operand data, immediate, indices, controls)
//   ex_*/mem_*            bypass sources (write enable, destination, result)
//   out_valid/out_ready   EX handshake
//   op1, op2              forwarded ALU operands
//   opcode/funct3/funct7  ALU controls
//   rd                    destination index of the held instruction
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_rs1_data,
  input  logic [WIDTH-1:0]   in_rs2_data,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic               in_use_imm,
  input  logic [REGADDR-1:0] in_rs1,
  input  logic [REGADDR-1:0] in_rs2,
  input  logic [REGADDR-1:0] in_rd,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic               ex_wen,
  input  logic [REGADDR-1:0] ex_rd,
  input  logic [WIDTH-1:0]   ex_result,
  input  logic               mem_wen,
  input  logic [REGADDR-1:0] mem_rd,
  input  logic [WIDTH-1:0]   mem_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   op1,
  output logic [WIDTH-1:0]   op2,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [REGADDR-1:0] rd
);

  logic               held_valid;
  logic [WIDTH-1:0]   held_rs1_data;
  logic [WIDTH-1:0]   held_rs2_data;
  logic [WIDTH-1:0]   held_imm;
  logic               held_use_imm;
  logic [REGADDR-1:0] held_rs1;
  logic [REGADDR-1:0] held_rs2;
  logic [REGADDR-1:0] held_rd;
  logic [6:0]         held_opcode;
  logic [2:0]         held_funct3;
  logic [6:0]         held_funct7;

  logic [WIDTH-1:0]   fwd1;
  logic [WIDTH-1:0]   fwd2;
  logic               capture;

  assign in_ready = !held_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // EX is the younger producer, so it takes priority over MEM. x0 is never
  // forwarded because it is hard-wired and has no real producer.
  always_comb begin
    fwd1 = held_rs1_data;
    if (held_rs1 != '0) begin
      if (ex_wen && (ex_rd == held_rs1)) begin
        fwd1 = ex_result;
      end else if (mem_wen && (mem_rd == held_rs1)) begin
        fwd1 = mem_result;
      end
    end
  end

  always_comb begin
    fwd2 = held_rs2_data;
    if (held_rs2 != '0) begin
      if (ex_wen && (ex_rd == held_rs2)) begin
        fwd2 = ex_result;
      end else if (mem_wen && (mem_rd == held_rs2)) begin
        fwd2 = mem_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid    <= 1'b0;
      held_rs1_data <= '0;
      held_rs2_data <= '0;
      held_imm      <= '0;
      held_use_imm  <= 1'b0;
      held_rs1      <= '0;
      held_rs2      <= '0;
      held_rd       <= '0;
      held_opcode   <= '0;
      held_funct3   <= '0;
      held_funct7   <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid    <= 1'b1;
      held_rs1_data <= in_rs1_data;
      held_rs2_data <= in_rs2_data;
      held_imm      <= in_imm;
      held_use_imm  <= in_use_imm;
      held_rs1      <= in_rs1;
      held_rs2      <= in_rs2;
      held_rd       <= in_rd;
      held_opcode   <= in_opcode;
      held_funct3   <= in_funct3;
      held_funct7   <= in_funct7;
    end else if (held_valid && out_ready) begin
      held_valid <= 1'b0;
    end else if (held_valid) begin
      // Stalled: latch the forwarded values so that a producer which retires
      // out of EX/MEM during the stall is not lost.
      held_rs1_data <= fwd1;
      held_rs2_data <= fwd2;
    end
  end

  assign out_valid = held_valid;
  assign op1       = fwd1;
  assign op2       = held_use_imm ? held_imm : fwd2;
  assign opcode    = held_opcode;
  assign funct3    = held_funct3;
  assign funct7    = held_funct7;
  assign rd        = held_rd;

endmodule
